// File: rtl/serial_word_shifter.sv
// serial_word_shifter: turns parallel words from a valid/ready source into a
// one-bit-per-clock stream, with a holding register behind the shift register
// so back-to-back words leave no bubble, optional fill cycles between frames
// and frame_start/frame_end markers.
// Optional feature: define SERIAL_PARITY_EN to append an even-parity bit
// (XOR of the word) after the data bits of every frame.
module serial_word_shifter #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 0,
   parameter bit FILL_BIT   = 1'b0,
   parameter bit LSB_FIRST  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

`ifdef SERIAL_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CNT_W = $clog2(WIDTH + 2);
   // bit_cnt holds the index of the bit currently on ser_out
   localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_BIT_M1 = CNT_W'(FRAME_LEN - 2);
`ifdef SERIAL_PARITY_EN
   localparam logic [CNT_W-1:0] LAST_DATA   = CNT_W'(WIDTH - 1);
`endif
   localparam logic [3:0] LAST_GAP = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [WIDTH-1:0] hold_reg, hold_next;
   logic             hold_full_reg, hold_full_next;
   logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
   logic [3:0]       gap_cnt_reg, gap_cnt_next;
`ifdef SERIAL_PARITY_EN
   logic             parity_reg, parity_next;
`endif
   logic             ser_out_reg, ser_out_next;
   logic             ser_valid_reg, ser_valid_next;
   logic             frame_start_reg, frame_start_next;
   logic             frame_end_reg, frame_end_next;
   logic             busy_reg, busy_next;
   logic             din_ready_reg, din_ready_next;

   logic             accept;
   logic             avail;
   logic             load;
   logic [WIDTH-1:0] load_word;

   // din_ready always mirrors the holding register, so an accepted word never
   // finds the holding register full
   assign accept    = din_valid && din_ready_reg;
   assign avail     = hold_full_reg || accept;
   assign load_word = hold_full_reg ? hold_reg : din;

   // State and registered outputs; reset clears everything without a clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         shift_reg       <= '0;
         hold_reg        <= '0;
         hold_full_reg   <= 1'b0;
         bit_cnt_reg     <= '0;
         gap_cnt_reg     <= '0;
`ifdef SERIAL_PARITY_EN
         parity_reg      <= 1'b0;
`endif
         ser_out_reg     <= FILL_BIT;
         ser_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_end_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         din_ready_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         shift_reg       <= shift_next;
         hold_reg        <= hold_next;
         hold_full_reg   <= hold_full_next;
         bit_cnt_reg     <= bit_cnt_next;
         gap_cnt_reg     <= gap_cnt_next;
`ifdef SERIAL_PARITY_EN
         parity_reg      <= parity_next;
`endif
         ser_out_reg     <= ser_out_next;
         ser_valid_reg   <= ser_valid_next;
         frame_start_reg <= frame_start_next;
         frame_end_reg   <= frame_end_next;
         busy_reg        <= busy_next;
         din_ready_reg   <= din_ready_next;
      end
   end

   // Next-state, datapath and next-output logic (outputs describe the bit
   // that will be on the line during the following cycle)
   always_comb begin
      state_next       = state_reg;
      shift_next       = shift_reg;
      hold_next        = hold_reg;
      hold_full_next   = hold_full_reg;
      bit_cnt_next     = bit_cnt_reg;
      gap_cnt_next     = gap_cnt_reg;
`ifdef SERIAL_PARITY_EN
      parity_next      = parity_reg;
`endif
      ser_out_next     = FILL_BIT;
      ser_valid_next   = 1'b0;
      frame_start_next = 1'b0;
      frame_end_next   = 1'b0;
      load             = 1'b0;

      case (state_reg)
         IDLE: begin
            if (avail) load = 1'b1;
         end
         SHIFT: begin
            if (bit_cnt_reg == LAST_BIT) begin
               if (GAP_CYCLES > 0) begin
                  state_next   = GAP;
                  gap_cnt_next = '0;
               end else if (avail) begin
                  load = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               bit_cnt_next   = bit_cnt_reg + 1'b1;
               ser_valid_next = 1'b1;
               frame_end_next = (bit_cnt_reg == LAST_BIT_M1);
`ifdef SERIAL_PARITY_EN
               if (bit_cnt_reg == LAST_DATA) begin
                  ser_out_next = parity_reg;
               end else
`endif
               if (LSB_FIRST) begin
                  ser_out_next = shift_reg[0];
                  shift_next   = shift_reg >> 1;
               end else begin
                  ser_out_next = shift_reg[WIDTH-1];
                  shift_next   = shift_reg << 1;
               end
            end
         end
         GAP: begin
            if (gap_cnt_reg == LAST_GAP) begin
               if (avail) load = 1'b1;
               else       state_next = IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Frame load: first bit goes straight to the output register, the rest
      // stay in the shift register
      if (load) begin
         state_next       = SHIFT;
         bit_cnt_next     = '0;
         ser_valid_next   = 1'b1;
         frame_start_next = 1'b1;
`ifdef SERIAL_PARITY_EN
         parity_next      = ^load_word;
`endif
         if (LSB_FIRST) begin
            ser_out_next = load_word[0];
            shift_next   = load_word >> 1;
         end else begin
            ser_out_next = load_word[WIDTH-1];
            shift_next   = load_word << 1;
         end
      end

      // Holding register: refilled by a word arriving while it drains, filled
      // by a word arriving while the line is busy
      if (load && hold_full_reg) begin
         hold_full_next = accept;
         if (accept) hold_next = din;
      end else if (!load && accept) begin
         hold_full_next = 1'b1;
         hold_next      = din;
      end

      busy_next      = (state_next != IDLE) || hold_full_next;
      din_ready_next = !hold_full_next;
   end

   assign din_ready   = din_ready_reg;
   assign ser_out     = ser_out_reg;
   assign ser_valid   = ser_valid_reg;
   assign frame_start = frame_start_reg;
   assign frame_end   = frame_end_reg;
   assign busy        = busy_reg;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Testbench for serial_word_shifter: two instances (no gap / MSB first / fill 0
// and 3-cycle gap / LSB first / fill 1) driven with directed and random words.
// Expected outputs come from a frame schedule: each accepted word starts on
// the line at max(accept cycle, line free cycle) and occupies FRAME_LEN bits
// plus the gap.
`timescale 1ns/1ps
module tb_serial_word_shifter;
   localparam int W = 8;
`ifdef SERIAL_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif
   localparam int GAP0 = 0;
   localparam int GAP1 = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] din [2];
   logic [1:0]   din_valid;
   logic [1:0]   din_ready;
   logic [1:0]   ser_out;
   logic [1:0]   ser_valid;
   logic [1:0]   frame_start;
   logic [1:0]   frame_end;
   logic [1:0]   busy;

   always #5 clk = ~clk;

   serial_word_shifter #(.WIDTH(W), .GAP_CYCLES(GAP0), .FILL_BIT(1'b0), .LSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
      .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .frame_start(frame_start[0]),
      .frame_end(frame_end[0]), .busy(busy[0]));

   serial_word_shifter #(.WIDTH(W), .GAP_CYCLES(GAP1), .FILL_BIT(1'b1), .LSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
      .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .frame_start(frame_start[1]),
      .frame_end(frame_end[1]), .busy(busy[1]));

   typedef struct {
      int           inst;
      logic [W-1:0] word;
      int           acc;
      int           start;
   } frame_t;

   typedef struct packed {
      logic ready;
      logic busy;
      logic fe;
      logic fs;
      logic valid;
      logic out;
   } exp_t;

   frame_t     fq[$];
   int         line_free [2];
   int         cyc;
   int         checks;
   int         errors;
   logic [1:0] last_acc;

   function automatic int gap_of(int i);
      return (i == 0) ? GAP0 : GAP1;
   endfunction

   function automatic logic fill_of(int i);
      return (i == 0) ? 1'b0 : 1'b1;
   endfunction

   function automatic logic lsb_of(int i);
      return (i == 1);
   endfunction

   // Expected outputs of instance i during cycle c (the cycle after edge c)
   function automatic exp_t expect_at(int i, int c);
      exp_t e;
      logic held;
      int   off;
      int   idx;
      e     = '0;
      e.out = fill_of(i);
      held  = 1'b0;
      foreach (fq[k]) begin
         if (fq[k].inst == i) begin
            off = c - fq[k].start;
            if (off >= 0 && off < FL) begin
               e.valid = 1'b1;
               e.fs    = (off == 0);
               e.fe    = (off == FL - 1);
               if (off == W) begin
                  e.out = ^fq[k].word;
               end else begin
                  idx   = lsb_of(i) ? off : (W - 1 - off);
                  e.out = fq[k].word[idx];
               end
            end
            if (off >= 0 && off < FL + gap_of(i)) e.busy = 1'b1;
            if (fq[k].acc <= c && c < fq[k].start) held = 1'b1;
         end
      end
      e.busy  = e.busy | held;
      e.ready = (c >= 1) && !held;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   task automatic check_all();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         e = expect_at(i, cyc);
         check($sformatf("i%0d c%0d ser_out", i, cyc), 32'(ser_out[i]), 32'(e.out));
         check($sformatf("i%0d c%0d ser_valid", i, cyc), 32'(ser_valid[i]), 32'(e.valid));
         check($sformatf("i%0d c%0d frame_start", i, cyc), 32'(frame_start[i]), 32'(e.fs));
         check($sformatf("i%0d c%0d frame_end", i, cyc), 32'(frame_end[i]), 32'(e.fe));
         check($sformatf("i%0d c%0d busy", i, cyc), 32'(busy[i]), 32'(e.busy));
         check($sformatf("i%0d c%0d din_ready", i, cyc), 32'(din_ready[i]), 32'(e.ready));
      end
   endtask

   task automatic push(input int i, input logic [W-1:0] w, input int e);
      frame_t f;
      f.inst  = i;
      f.word  = w;
      f.acc   = e;
      f.start = (e > line_free[i]) ? e : line_free[i];
      line_free[i] = f.start + FL + gap_of(i);
      fq.push_back(f);
      $display("inst %0d: word %02h accepted at cycle %0d, frame starts cycle %0d",
               i, w, e, f.start);
   endtask

   // One clock: acceptance follows the predicted din_ready, then check outputs
   task automatic step();
      logic [1:0] acc;
      exp_t       e;
      for (int i = 0; i < 2; i++) begin
         e      = expect_at(i, cyc);
         acc[i] = din_valid[i] && e.ready;
      end
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) if (acc[i]) push(i, din[i], cyc);
      last_acc = acc;
      while (fq.size() > 0 && fq[0].start + FL + 8 < cyc) void'(fq.pop_front());
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic send(input int i, input logic [W-1:0] w);
      int n;
      n            = 0;
      din[i]       = w;
      din_valid[i] = 1'b1;
      do begin
         step();
         n++;
      end while (!last_acc[i] && n < 40);
      check($sformatf("i%0d send %02h accepted", i, w), 32'(last_acc[i]), 32'd1);
      din_valid[i] = 1'b0;
   endtask

   task automatic clear_model();
      fq.delete();
      line_free[0] = 0;
      line_free[1] = 0;
      cyc          = 0;
      last_acc     = '0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      din[0]    = '0;
      din[1]    = '0;
      din_valid = '0;
      clear_model();

      // Reset state, then release: din_ready must wait for the first edge
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b1;
      #1;
      check_all();

      // Single word, MSB first, no gap
      send(0, 8'hD4);
      idle(10);
      // Back-to-back words with din_valid held high
      send(0, 8'hFF);
      send(0, 8'h00);
      idle(20);
      // Gap insertion and LSB-first order on the second instance
      send(1, 8'hA5);
      send(1, 8'h5A);
      idle(30);
      send(1, 8'h01);
      idle(12);
      // Parity-relevant words
      send(0, 8'h07);
      idle(12);
      send(0, 8'h03);
      idle(12);

      // Random traffic on both instances; din held stable until accepted
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < 2; i++) begin
            if (!din_valid[i] || last_acc[i]) begin
               din_valid[i] = ($urandom_range(0, 3) != 0);
               din[i]       = W'($urandom);
            end
         end
         step();
      end
      din_valid = '0;
      idle(30);

      // Reset in the middle of a frame: outputs clear without a clock
      send(0, 8'hD4);
      step();
      step();
      #2 rst = 1'b0;
      #1;
      clear_model();
      check_all();
      @(negedge clk);
      rst = 1'b1;
      check_all();
      send(0, 8'h3C);
      idle(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
